// File: rtl/hdmi_chan_deskew_pkg.sv
// Shared HDMI definitions: TMDS control tokens, control-run threshold, deskew FSM states.
package hdmi_chan_deskew_pkg;

    localparam logic [9:0] CTL_TOKEN_0 = 10'h354;
    localparam logic [9:0] CTL_TOKEN_1 = 10'h0AB;
    localparam logic [9:0] CTL_TOKEN_2 = 10'h154;
    localparam logic [9:0] CTL_TOKEN_3 = 10'h2AB;
    localparam int         CTL_RUN_MIN = 8;

    localparam int LANE_B = 0;
    localparam int LANE_G = 1;
    localparam int LANE_R = 2;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_WINDOW = 2'd1,
        S_EVAL   = 2'd2
    } deskew_state_e;

    function automatic logic is_ctl_token(input logic [9:0] w);
        return (w == CTL_TOKEN_0) || (w == CTL_TOKEN_1) ||
               (w == CTL_TOKEN_2) || (w == CTL_TOKEN_3);
    endfunction

endpackage

// File: rtl/hdmi_chan_deskew_lane.sv
// One TMDS lane: tapped delay line with registered output mux, control-run counter
// and registered control-to-data edge flag (measured on the undelayed input).
module hdmi_deskew_lane
    import hdmi_chan_deskew_pkg::*;
#(
    parameter int MAX_SKEW = 3
) (
    input  logic       i_pix_clk,
    input  logic       i_reset_n,
    input  logic       clear,
    input  logic [9:0] word_in,
    input  logic [2:0] delay,
    output logic [9:0] word_out,
    output logic       edge_flag
);

    logic [9:0] sr [1:MAX_SKEW];
    logic [9:0] taps [0:7];
    logic [3:0] run;

    // Unused tap slots repeat the deepest stage so the 3-bit select is always in range.
    for (genvar k = 0; k < 8; k++) begin : g_tap
        if (k == 0) begin : g_in
            assign taps[k] = word_in;
        end else if (k <= MAX_SKEW) begin : g_sr
            assign taps[k] = sr[k];
        end else begin : g_hold
            assign taps[k] = sr[MAX_SKEW];
        end
    end

    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 1; k <= MAX_SKEW; k++) sr[k] <= '0;
            word_out <= '0;
        end else begin
            sr[1] <= word_in;
            for (int k = 2; k <= MAX_SKEW; k++) sr[k] <= sr[k-1];
            word_out <= taps[delay];
        end
    end

    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            run       <= '0;
            edge_flag <= 1'b0;
        end else if (clear) begin
            run       <= '0;
            edge_flag <= 1'b0;
        end else begin
            if (is_ctl_token(word_in)) begin
                run <= (run == 4'd15) ? 4'd15 : run + 4'd1;
            end else begin
                run <= '0;
            end
            edge_flag <= !is_ctl_token(word_in) && (run >= 4'(CTL_RUN_MIN));
        end
    end

endmodule

// File: rtl/hdmi_chan_deskew.sv
// Inter-channel TMDS word aligner: measures lane skew at blanking-to-data edges and delays early lanes.
// Optional unlock statistics in o_skew_word[31:16] when HDMI_DESKEW_STATS_EN is defined.
module hdmi_chan_deskew
    import hdmi_chan_deskew_pkg::*;
#(
    parameter int MAX_SKEW   = 3,
    parameter int LOCK_COUNT = 4
) (
    input  logic          i_pix_clk,
    input  logic          i_reset_n,
    input  logic          i_bit_locked,
    input  logic [9:0]    i_r,
    input  logic [9:0]    i_g,
    input  logic [9:0]    i_b,
    output logic [9:0]    o_r,
    output logic [9:0]    o_g,
    output logic [9:0]    o_b,
    output logic          o_aligned,
    output logic [31:0]   o_skew_word,
    output deskew_state_e o_dbg_state
);

    deskew_state_e state;
    logic [9:0]  lane_in  [3];
    logic [9:0]  lane_out [3];
    logic [2:0]  edges;
    logic [2:0]  have;
    logic [2:0]  off    [3];
    logic [2:0]  stored [3];
    logic [2:0]  delay  [3];
    logic [2:0]  win, win_nxt, max_off;
    logic [3:0]  match_cnt, match_nxt;
    logic [1:0]  fail_cnt;
    logic        aligned, all_have, same, good_meas, unlock_evt;
    logic [15:0] unlock_cnt;

    assign lane_in[LANE_R] = i_r;
    assign lane_in[LANE_G] = i_g;
    assign lane_in[LANE_B] = i_b;

    for (genvar x = 0; x < 3; x++) begin : g_lane
        hdmi_deskew_lane #(.MAX_SKEW(MAX_SKEW)) u_lane (
            .i_pix_clk (i_pix_clk),
            .i_reset_n (i_reset_n),
            .clear     (!i_bit_locked),
            .word_in   (lane_in[x]),
            .delay     (delay[x]),
            .word_out  (lane_out[x]),
            .edge_flag (edges[x])
        );
    end

    always_comb begin
        all_have  = &have;
        same      = (off[0] == stored[0]) && (off[1] == stored[1]) && (off[2] == stored[2]);
        good_meas = all_have && same;
        max_off   = off[0];
        if (off[1] > max_off) max_off = off[1];
        if (off[2] > max_off) max_off = off[2];
        match_nxt = same ? ((match_cnt == 4'd15) ? 4'd15 : match_cnt + 4'd1) : 4'd1;
        win_nxt   = win + 3'd1;
        // Second consecutive bad measurement while aligned, or bit-lock loss while aligned.
        unlock_evt = aligned && (!i_bit_locked ||
                     (state == S_EVAL && !good_meas && fail_cnt == 2'd1));
    end

    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= S_WAIT;
            win       <= '0;
            have      <= '0;
            match_cnt <= '0;
            fail_cnt  <= '0;
            aligned   <= 1'b0;
            for (int x = 0; x < 3; x++) begin
                off[x]    <= '0;
                stored[x] <= '0;
                delay[x]  <= '0;
            end
        end else if (!i_bit_locked) begin
            state     <= S_WAIT;
            win       <= '0;
            have      <= '0;
            match_cnt <= '0;
            fail_cnt  <= '0;
            aligned   <= 1'b0;
            for (int x = 0; x < 3; x++) begin
                off[x]    <= '0;
                stored[x] <= '0;
                delay[x]  <= '0;
            end
        end else begin
            case (state)
                S_WAIT: begin
                    if (|edges) begin
                        state <= S_WINDOW;
                        win   <= '0;
                        have  <= edges;
                        for (int x = 0; x < 3; x++) off[x] <= '0;
                    end
                end
                S_WINDOW: begin
                    win <= win_nxt;
                    for (int x = 0; x < 3; x++) begin
                        if (edges[x] && !have[x]) begin
                            have[x] <= 1'b1;
                            off[x]  <= win_nxt;
                        end
                    end
                    if (win_nxt == 3'(MAX_SKEW)) state <= S_EVAL;
                end
                S_EVAL: begin
                    state <= S_WAIT;
                    if (aligned) begin
                        // Stored offsets define the applied delays and stay put until unlock.
                        if (good_meas) begin
                            fail_cnt  <= '0;
                            match_cnt <= match_nxt;
                        end else if (unlock_evt) begin
                            aligned   <= 1'b0;
                            match_cnt <= '0;
                            fail_cnt  <= '0;
                            for (int x = 0; x < 3; x++) delay[x] <= '0;
                        end else begin
                            fail_cnt <= fail_cnt + 2'd1;
                        end
                    end else if (!all_have) begin
                        match_cnt <= '0;
                    end else begin
                        match_cnt <= match_nxt;
                        if (!same) begin
                            for (int x = 0; x < 3; x++) stored[x] <= off[x];
                        end
                        if (match_nxt >= 4'(LOCK_COUNT)) begin
                            aligned  <= 1'b1;
                            fail_cnt <= '0;
                            for (int x = 0; x < 3; x++) delay[x] <= max_off - off[x];
                        end
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

`ifdef HDMI_DESKEW_STATS_EN
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            unlock_cnt <= '0;
        end else if (unlock_evt && unlock_cnt != 16'hFFFF) begin
            unlock_cnt <= unlock_cnt + 16'd1;
        end
    end
`else
    assign unlock_cnt = '0;
`endif

    assign o_r         = lane_out[LANE_R];
    assign o_g         = lane_out[LANE_G];
    assign o_b         = lane_out[LANE_B];
    assign o_aligned   = aligned;
    assign o_dbg_state = state;
    assign o_skew_word = {unlock_cnt, 3'b000, aligned, 1'b0, delay[LANE_R],
                          1'b0, delay[LANE_G], 1'b0, delay[LANE_B]};

endmodule

// File: tb/tb_hdmi_chan_deskew.sv
// Directed bench for hdmi_chan_deskew: expected outputs queued per cycle, compared by a monitor.
module tb_hdmi_chan_deskew;
  import hdmi_chan_deskew_pkg::*;

  localparam int NCTL = 12;
  localparam int NPER = 28;

  logic          i_pix_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_bit_locked = 1'b0;
  logic [9:0]    i_r = '0, i_g = '0, i_b = '0;
  logic [9:0]    o_r, o_g, o_b;
  logic          o_aligned;
  logic [31:0]   o_skew_word;
  deskew_state_e o_dbg_state;

  // clock / reset block
  always #5 i_pix_clk = ~i_pix_clk;

  hdmi_chan_deskew #(.MAX_SKEW(3), .LOCK_COUNT(4)) dut (
    .i_pix_clk    (i_pix_clk),
    .i_reset_n    (i_reset_n),
    .i_bit_locked (i_bit_locked),
    .i_r          (i_r),
    .i_g          (i_g),
    .i_b          (i_b),
    .o_r          (o_r),
    .o_g          (o_g),
    .o_b          (o_b),
    .o_aligned    (o_aligned),
    .o_skew_word  (o_skew_word),
    .o_dbg_state  (o_dbg_state)
  );

  // one entry per clock: what the outputs must show after that edge
  typedef struct packed {
    logic        chk_d;
    logic [29:0] d;
    logic        chk_s;
    logic [31:0] s;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_unl = 0;

  function automatic logic [9:0] base_word(input int lane, input int p, input int k);
    logic [9:0] toks [4];
    logic [9:0] w;
    toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    if (k < NCTL) return toks[(k + lane) % 4];
    w = 10'((lane + 1) * 256 + p * 37 + k * 3);
    if (w == 10'h354 || w == 10'h0AB || w == 10'h154 || w == 10'h2AB) w = w ^ 10'h001;
    return w;
  endfunction

  function automatic logic [9:0] lane_word(input int lane, input int p, input int j, input int s);
    if (j < s) return 10'h354;
    return base_word(lane, p, j - s);
  endfunction

  function automatic logic [31:0] stat_word(input logic al, input logic [2:0] dr, dg, db);
    logic [15:0] u;
    u = '0;
`ifdef HDMI_DESKEW_STATS_EN
    u = 16'(exp_unl);
`endif
    return {u, 3'b000, al, 1'b0, dr, 1'b0, dg, 1'b0, db};
  endfunction

  // driver tasks
  task automatic step(input logic [9:0] r, g, b, input logic lk, input exp_t e);
    i_r = r; i_g = g; i_b = b; i_bit_locked = lk;
    @(posedge i_pix_clk);
    exp_q.push_back(e);
    #1;
  endtask

  // One blanking+data period, lane skews sr/sg/sb; data checked with total latency-1 = m.
  task automatic run_period(input int p, input int sr, sg, sb, input logic chk_d, input int m,
                            input logic [31:0] stat, input int rst_at);
    for (int j = 0; j < NPER; j++) begin
      exp_t e;
      e = '0;
      if (chk_d && j >= m) begin
        e.chk_d = 1'b1;
        e.d = {base_word(2, p, j - m), base_word(1, p, j - m), base_word(0, p, j - m)};
      end
      if (j == NPER - 1) begin
        e.chk_s = 1'b1;
        e.s = stat;
      end
      // reset is asserted 1 time unit after this edge, so this observation must already be zero
      if (rst_at >= 0 && j >= rst_at && j <= rst_at + 2) begin
        e.chk_d = 1'b1; e.d = '0; e.chk_s = 1'b1; e.s = '0;
      end
      if (rst_at >= 0 && j == rst_at + 3) i_reset_n = 1'b1;
      step(lane_word(2, p, j, sr), lane_word(1, p, j, sg), lane_word(0, p, j, sb), 1'b1, e);
      if (rst_at >= 0 && j == rst_at) i_reset_n = 1'b0;
    end
  endtask

  // scoreboard monitor
  always @(negedge i_pix_clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.chk_d) begin
        n_cmp++;
        if ({o_r, o_g, o_b} !== mon_e.d) begin
          n_bad++;
          $display("FAIL data t=%0t got r=%h g=%h b=%h want r=%h g=%h b=%h", $time,
                   o_r, o_g, o_b, mon_e.d[29:20], mon_e.d[19:10], mon_e.d[9:0]);
        end
      end
      if (mon_e.chk_s) begin
        n_cmp++;
        if (o_skew_word !== mon_e.s) begin
          n_bad++;
          $display("FAIL skew_word t=%0t got %h want %h", $time, o_skew_word, mon_e.s);
        end
        n_cmp++;
        if (o_aligned !== mon_e.s[12]) begin
          n_bad++;
          $display("FAIL aligned t=%0t got %b want %b", $time, o_aligned, mon_e.s[12]);
        end
      end
    end
  end

  initial begin
    exp_t e0;
    int p;
    e0 = '0; e0.chk_d = 1'b1; e0.chk_s = 1'b1;
    p = 0;
    // reset state
    step(10'h0, 10'h0, 10'h0, 1'b0, e0);
    step(10'h0, 10'h0, 10'h0, 1'b0, e0);
    i_reset_n = 1'b1;

    // zero skew: align after the 4th evaluation, 1-cycle latency throughout
    for (int k = 0; k < 5; k++) begin
      run_period(p, 0, 0, 0, 1'b1, 0, stat_word(k >= 3, 3'd0, 3'd0, 3'd0), -1);
      p++;
    end

    // skew r+2 g+0 b+1 after lock: first miss holds, second unlocks, relock after 4 more
    run_period(p, 2, 0, 1, 1'b0, 0, stat_word(1'b1, 3'd0, 3'd0, 3'd0), -1); p++;
    exp_unl++;
    run_period(p, 2, 0, 1, 1'b0, 0, stat_word(1'b0, 3'd0, 3'd0, 3'd0), -1); p++;
    for (int k = 0; k < 3; k++) begin
      run_period(p, 2, 0, 1, 1'b0, 0, stat_word(1'b0, 3'd0, 3'd0, 3'd0), -1); p++;
    end
    run_period(p, 2, 0, 1, 1'b0, 0, stat_word(1'b1, 3'd0, 3'd2, 3'd1), -1); p++;
    run_period(p, 2, 0, 1, 1'b1, 2, stat_word(1'b1, 3'd0, 3'd2, 3'd1), -1); p++;

    // bit-lock loss while aligned
    exp_unl++;
    e0 = '0; e0.chk_s = 1'b1; e0.s = stat_word(1'b0, 3'd0, 3'd0, 3'd0);
    step(10'h354, 10'h354, 10'h354, 1'b0, e0);

    // skew of 4 on lane r exceeds MAX_SKEW=3: never aligns
    for (int k = 0; k < 5; k++) begin
      run_period(p, 4, 0, 0, 1'b0, 0, stat_word(1'b0, 3'd0, 3'd0, 3'd0), -1); p++;
    end

    // two matches, then reset mid-window; four fresh matches needed afterwards
    for (int k = 0; k < 2; k++) begin
      run_period(p, 0, 0, 0, 1'b1, 0, stat_word(1'b0, 3'd0, 3'd0, 3'd0), -1); p++;
    end
    exp_unl = 0;
    run_period(p, 0, 0, 0, 1'b0, 0, stat_word(1'b0, 3'd0, 3'd0, 3'd0), 14); p++;
    for (int k = 0; k < 4; k++) begin
      run_period(p, 0, 0, 0, 1'b1, 0, stat_word(k == 3, 3'd0, 3'd0, 3'd0), -1); p++;
    end

    repeat (2) @(negedge i_pix_clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish want finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
